// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and the two-digit display counter:
// the receiver FSM encoding and the active-low segment patterns (a..g,dp in bits 7..0).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h19;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/ascii_to_seg.sv
// Combinational ASCII-digit to active-low seven-segment decode.
// Anything other than '0'..'9' maps to SEG_BLANK, which the display counter ignores.
module ascii_to_seg
  import uart_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (ascii)
      8'h30:   seg = SEG_0;
      8'h31:   seg = SEG_1;
      8'h32:   seg = SEG_2;
      8'h33:   seg = SEG_3;
      8'h34:   seg = SEG_4;
      8'h35:   seg = SEG_5;
      8'h36:   seg = SEG_6;
      8'h37:   seg = SEG_7;
      8'h38:   seg = SEG_8;
      8'h39:   seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/uart_rx_seg.sv
// UART 8N1 receiver with registered seven-segment decode of each received byte.
// Handshake: flag / frame_err are single-cycle strobes with no back-pressure; rx_data and seg_code hold until the next good frame.
module uart_rx_seg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       flag,
  output logic [7:0] rx_data,
  output logic [7:0] seg_code,
  output logic       frame_err
);

  localparam int BIT_CNT  = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = $clog2(BIT_CNT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

  logic          rx_s1, rx_s, rx_d;
  logic          fall;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [7:0]    seg_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s  <= rx_s1;
      rx_d  <= rx_s;
    end
  end

  // Only a high-to-low transition starts a frame, so a line stuck low stays quiet.
  assign fall = rx_d & ~rx_s;

  ascii_to_seg u_dec (
    .ascii (shreg),
    .seg   (seg_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= 8'h00;
      seg_code  <= SEG_BLANK;
      flag      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      flag      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Returning to IDLE at mid-stop-bit leaves half a bit to catch an unbroken next start edge.
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              rx_data  <= shreg;
              seg_code <= seg_next;
              flag     <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_seg.sv
// Bench for uart_rx_seg at CLK_FREQ=16, BAUD=1: one bit lasts 16 clocks.
module tb_uart_rx_seg;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       flag;
  logic [7:0] rx_data;
  logic [7:0] seg_code;
  logic       frame_err;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [7:0] exp_q[$];

  int  flag_cnt = 0, flag_hi = 0, ferr_cnt = 0, ferr_hi = 0;
  int  last_flag_cyc = 0, prev_flag_cyc = 0, last_ferr_cyc = 0;
  int  start_cyc = 0;
  logic prev_flag = 1'b0, prev_ferr = 1'b0;

  uart_rx_seg #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .flag      (flag),
    .rx_data   (rx_data),
    .seg_code  (seg_code),
    .frame_err (frame_err)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] seg_of(input logic [7:0] b);
    case (b)
      8'h30: return 8'h03;
      8'h31: return 8'h9F;
      8'h32: return 8'h25;
      8'h33: return 8'h0D;
      8'h34: return 8'h99;
      8'h35: return 8'h49;
      8'h36: return 8'h41;
      8'h37: return 8'h1F;
      8'h38: return 8'h01;
      8'h39: return 8'h19;
      default: return 8'hFF;
    endcase
  endfunction

  // Scoreboard: each flag consumes one expected byte
  always @(negedge clk) begin
    logic [7:0] e;
    if (flag) begin
      flag_hi++;
      if (!prev_flag) begin
        flag_cnt++;
        prev_flag_cyc = last_flag_cyc;
        last_flag_cyc = cyc;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_flag: rx_data=%h with no byte expected", rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            mismatched++;
            $display("FAIL sb_rx_data: got %h expected %h", rx_data, e);
          end
          compared++;
          if (seg_code !== seg_of(e)) begin
            mismatched++;
            $display("FAIL sb_seg_code: got %h expected %h", seg_code, seg_of(e));
          end
        end
      end
    end
    if (frame_err) begin
      ferr_hi++;
      if (!prev_ferr) begin
        ferr_cnt++;
        last_ferr_cyc = cyc;
      end
    end
    if (flag || frame_err) begin
      compared++;
      if (flag && frame_err) begin
        mismatched++;
        $display("FAIL strobe_overlap: flag=%b frame_err=%b expected not both", flag, frame_err);
      end
    end
    prev_flag = flag;
    prev_ferr = frame_err;
  end

  // Driver tasks (always entered and left on a falling clock edge)
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      rx = 1'($urandom_range(0, 1));
      @(negedge clk);
      compared++;
      if (seg_code !== 8'hFF || rx_data !== 8'h00 || flag !== 1'b0 || frame_err !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_hold: seg=%h data=%h flag=%b ferr=%b expected FF/00/0/0",
                 seg_code, rx_data, flag, frame_err);
      end
    end
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(40);
    check_int("reset_no_flag", flag_cnt, 0);
    check_int("reset_no_ferr", ferr_cnt, 0);
    compared++;
    if (dut.state !== IDLE) begin
      mismatched++;
      $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
    end
  endtask

  task automatic test_valid_digit();
    int f0 = flag_cnt, h0 = flag_hi, e0 = ferr_cnt;
    send_frame(8'h35, 1'b1);
    idle(20);
    check_int("digit_flag_count", flag_cnt - f0, 1);
    check_int("digit_flag_width", flag_hi - h0, 1);
    check_int("digit_no_ferr", ferr_cnt - e0, 0);
    check_int("digit_flag_timing", last_flag_cyc - start_cyc, 155);
    check_int("digit_rx_data", int'(rx_data), 32'h35);
    check_int("digit_seg", int'(seg_code), 32'h49);
  endtask

  task automatic test_non_digit();
    int f0 = flag_cnt;
    send_frame(8'h41, 1'b1);
    idle(20);
    check_int("nondigit_flag_count", flag_cnt - f0, 1);
    check_int("nondigit_rx_data", int'(rx_data), 32'h41);
    check_int("nondigit_seg", int'(seg_code), 32'hFF);
  endtask

  task automatic test_frame_err();
    int f0 = flag_cnt, e0 = ferr_cnt, eh0 = ferr_hi;
    send_frame(8'h37, 1'b0);
    check_int("ferr_count", ferr_cnt - e0, 1);
    check_int("ferr_width", ferr_hi - eh0, 1);
    check_int("ferr_no_flag", flag_cnt - f0, 0);
    check_int("ferr_timing", last_ferr_cyc - start_cyc, 155);
    check_int("ferr_rx_data_kept", int'(rx_data), 32'h41);
    check_int("ferr_seg_kept", int'(seg_code), 32'hFF);
    // line stays low after the bad stop bit
    rx = 1'b0;
    repeat (100) @(negedge clk);
    check_int("low_hold_no_flag", flag_cnt - f0, 0);
    check_int("low_hold_no_ferr", ferr_cnt - e0, 1);
    idle(40);
    check_int("low_release_no_flag", flag_cnt - f0, 0);
  endtask

  task automatic test_glitch();
    int f0 = flag_cnt, e0 = ferr_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(200);
    check_int("glitch_no_flag", flag_cnt - f0, 0);
    check_int("glitch_no_ferr", ferr_cnt - e0, 0);
    compared++;
    if (dut.state !== IDLE) begin
      mismatched++;
      $display("FAIL glitch_state: got %0d expected %0d", dut.state, IDLE);
    end
  endtask

  task automatic test_back_to_back();
    int f0 = flag_cnt;
    send_frame(8'h31, 1'b1);
    send_frame(8'h39, 1'b1);
    idle(20);
    check_int("b2b_flag_count", flag_cnt - f0, 2);
    check_int("b2b_spacing", last_flag_cyc - prev_flag_cyc, 160);
    check_int("b2b_seg", int'(seg_code), 32'h19);
    check_int("b2b_rx_data", int'(rx_data), 32'h39);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'h30;
    int f0 = flag_cnt, e0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(200);
    check_int("abort_no_flag", flag_cnt - f0, 0);
    check_int("abort_no_ferr", ferr_cnt - e0, 0);
    check_int("abort_rx_data", int'(rx_data), 0);
    check_int("abort_seg", int'(seg_code), 32'hFF);
    send_frame(8'h30, 1'b1);
    idle(20);
    check_int("after_abort_flag", flag_cnt - f0, 1);
    check_int("after_abort_seg", int'(seg_code), 32'h03);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_valid_digit();
    test_non_digit();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
